// File: rtl/pmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pmem_arbiter: round-robin I/D cache arbiter for the shared cacheline adaptor.
// Revision: 1.0
// ----------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int LINE_W         = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_mem_read,
  input  logic [ADDR_W-1:0]     i_mem_address,
  output logic [LINE_W-1:0]     i_mem_rdata,
  output logic                  i_mem_resp,

  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_W-1:0]     d_mem_address,
  input  logic [LINE_W-1:0]     d_mem_wdata,
  input  logic [LINE_W/8-1:0]   d_mem_byte_enable,
  output logic [LINE_W-1:0]     d_mem_rdata,
  output logic                  d_mem_resp,

  output logic                  ca_mem_read,
  output logic                  ca_mem_write,
  output logic [ADDR_W-1:0]     ca_mem_address,
  output logic [LINE_W-1:0]     ca_mem_wdata,
  output logic [LINE_W/8-1:0]   ca_mem_byte_enable,
  input  logic [LINE_W-1:0]     ca_mem_rdata,
  input  logic                  ca_mem_resp,

  output logic                  err_timeout
);

  localparam int c_BE_W = LINE_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_I  = 2'd1,
    ST_BUSY_D  = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_last_grant_d;
  logic                w_i_pend;
  logic                w_d_pend;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_busy;
  logic                w_done;

  logic                r_ca_read;
  logic                r_ca_write;
  logic [ADDR_W-1:0]   r_ca_address;
  logic [LINE_W-1:0]   r_ca_wdata;
  logic [c_BE_W-1:0]   r_ca_byte_enable;

  assign w_i_pend = i_mem_read;
  assign w_d_pend = d_mem_read | d_mem_write;
  assign w_busy   = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
  assign w_done   = w_busy & ca_mem_resp;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_i_pend && (!w_d_pend || r_last_grant_d)) begin
          w_grant_i    = 1'b1;
          w_state_next = ST_BUSY_I;
        end else if (w_d_pend) begin
          w_grant_d    = 1'b1;
          w_state_next = ST_BUSY_D;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (ca_mem_resp) begin
          w_state_next = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_last_grant_d <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_grant_i) begin
        r_last_grant_d <= 1'b0;
      end else if (w_grant_d) begin
        r_last_grant_d <= 1'b1;
      end
    end
  end

  // Adaptor port is driven purely from these registers; requester inputs are
  // only sampled at the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ca_read        <= 1'b0;
      r_ca_write       <= 1'b0;
      r_ca_address     <= '0;
      r_ca_wdata       <= '0;
      r_ca_byte_enable <= '0;
    end else if (w_grant_i) begin
      r_ca_read        <= 1'b1;
      r_ca_write       <= 1'b0;
      r_ca_address     <= i_mem_address;
      r_ca_wdata       <= '0;
      r_ca_byte_enable <= '0;
    end else if (w_grant_d) begin
      r_ca_read        <= ~d_mem_write;
      r_ca_write       <= d_mem_write;
      r_ca_address     <= d_mem_address;
      r_ca_wdata       <= d_mem_wdata;
      r_ca_byte_enable <= d_mem_byte_enable;
    end else if (w_done) begin
      r_ca_read  <= 1'b0;
      r_ca_write <= 1'b0;
    end
  end

  assign ca_mem_read        = r_ca_read;
  assign ca_mem_write       = r_ca_write;
  assign ca_mem_address     = r_ca_address;
  assign ca_mem_wdata       = r_ca_wdata;
  assign ca_mem_byte_enable = r_ca_byte_enable;

  assign i_mem_rdata = ca_mem_rdata;
  assign d_mem_rdata = ca_mem_rdata;
  assign i_mem_resp  = (r_state == ST_BUSY_I) & ca_mem_resp;
  assign d_mem_resp  = (r_state == ST_BUSY_D) & ca_mem_resp;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_watchdog
      localparam int                c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [c_CNT_W-1:0] c_LIMIT    = c_CNT_W'(TIMEOUT_CYCLES);
      localparam logic [c_CNT_W-1:0] c_LIMIT_M1 = c_CNT_W'(TIMEOUT_CYCLES - 1);

      logic [c_CNT_W-1:0] r_wd_count;
      logic               r_err;

      // Flag only; the stuck transaction is left to complete whenever it can.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_wd_count <= '0;
          r_err      <= 1'b0;
        end else begin
          if (w_grant_i || w_grant_d) begin
            r_wd_count <= '0;
          end else if (w_busy && !ca_mem_resp && (r_wd_count != c_LIMIT)) begin
            r_wd_count <= r_wd_count + c_CNT_W'(1);
          end
          if (w_busy && !ca_mem_resp && (r_wd_count == c_LIMIT_M1)) begin
            r_err <= 1'b1;
          end
        end
      end

      assign err_timeout = r_err;
    end else begin : g_no_watchdog
      assign err_timeout = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pmem_arbiter: directed and randomized checks of the I/D adaptor arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_pmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int BE_W   = LINE_W / 8;
  localparam int TMO    = 8;

  logic              clk;
  logic              rst;
  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_address;
  logic [LINE_W-1:0] i_mem_rdata;
  logic              i_mem_resp;
  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_address;
  logic [LINE_W-1:0] d_mem_wdata;
  logic [BE_W-1:0]   d_mem_byte_enable;
  logic [LINE_W-1:0] d_mem_rdata;
  logic              d_mem_resp;
  logic              ca_mem_read;
  logic              ca_mem_write;
  logic [ADDR_W-1:0] ca_mem_address;
  logic [LINE_W-1:0] ca_mem_wdata;
  logic [BE_W-1:0]   ca_mem_byte_enable;
  logic [LINE_W-1:0] ca_mem_rdata;
  logic              ca_mem_resp;
  logic              err_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  pmem_arbiter #(
    .ADDR_W         (ADDR_W),
    .LINE_W         (LINE_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_mem_read         (i_mem_read),
    .i_mem_address      (i_mem_address),
    .i_mem_rdata        (i_mem_rdata),
    .i_mem_resp         (i_mem_resp),
    .d_mem_read         (d_mem_read),
    .d_mem_write        (d_mem_write),
    .d_mem_address      (d_mem_address),
    .d_mem_wdata        (d_mem_wdata),
    .d_mem_byte_enable  (d_mem_byte_enable),
    .d_mem_rdata        (d_mem_rdata),
    .d_mem_resp         (d_mem_resp),
    .ca_mem_read        (ca_mem_read),
    .ca_mem_write       (ca_mem_write),
    .ca_mem_address     (ca_mem_address),
    .ca_mem_wdata       (ca_mem_wdata),
    .ca_mem_byte_enable (ca_mem_byte_enable),
    .ca_mem_rdata       (ca_mem_rdata),
    .ca_mem_resp        (ca_mem_resp),
    .err_timeout        (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got still running want finished");
    $fatal(1, "time limit");
  end

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // All stimulus changes on the falling edge; outputs are read there too.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    i_mem_read = 1'b0; i_mem_address = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0;
    d_mem_wdata = '0; d_mem_byte_enable = '0;
    ca_mem_rdata = '0; ca_mem_resp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_ca_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (ca_mem_read || ca_mem_write) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({ca_mem_read, ca_mem_write} !== 2'b00) $display("FAIL reset_ca_req: got %b want 00", {ca_mem_read, ca_mem_write}); else n_pass++;
    n_checks++; if (ca_mem_address !== '0) $display("FAIL reset_ca_addr: got %h want 0", ca_mem_address); else n_pass++;
    n_checks++; if (ca_mem_wdata !== '0 || ca_mem_byte_enable !== '0) $display("FAIL reset_ca_data: got %h/%h want 0/0", ca_mem_wdata, ca_mem_byte_enable); else n_pass++;
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL reset_err: got %b want 0", err_timeout); else n_pass++;
    ca_mem_resp = 1'b1;
    @(negedge clk);
    n_checks++; if ({i_mem_resp, d_mem_resp, ca_mem_read, ca_mem_write} !== 4'b0000) $display("FAIL idle_resp_ignored: got %b want 0000", {i_mem_resp, d_mem_resp, ca_mem_read, ca_mem_write}); else n_pass++;
    ca_mem_resp = 1'b0;
  endtask

  task automatic test_i_read();
    bit ok;
    i_mem_read = 1'b1; i_mem_address = 32'h0000_1000;
    #1;
    n_checks++; if (ca_mem_read !== 1'b0) $display("FAIL i_read_early: got %b want 0", ca_mem_read); else n_pass++;
    wait_ca_req(1, ok);
    n_checks++; if (!ok) $display("FAIL i_read_latency: got no request want ca_mem_read one cycle later"); else n_pass++;
    n_checks++; if ({ca_mem_read, ca_mem_write} !== 2'b10 || ca_mem_address !== 32'h0000_1000) $display("FAIL i_read_ca: got rw=%b addr=%h want rw=10 addr=00001000", {ca_mem_read, ca_mem_write}, ca_mem_address); else n_pass++;
    ca_mem_rdata = {32{8'hA5}}; ca_mem_resp = 1'b1;
    #1;
    n_checks++; if ({i_mem_resp, d_mem_resp} !== 2'b10) $display("FAIL i_read_resp: got i=%b d=%b want i=1 d=0", i_mem_resp, d_mem_resp); else n_pass++;
    n_checks++; if (i_mem_rdata !== {32{8'hA5}}) $display("FAIL i_read_rdata: got %h want a5..a5", i_mem_rdata); else n_pass++;
    @(negedge clk);
    i_mem_read = 1'b0;
    n_checks++; if ({ca_mem_read, ca_mem_write} !== 2'b00) $display("FAIL i_read_recover: got %b want 00", {ca_mem_read, ca_mem_write}); else n_pass++;
    // Resp held through RECOVER into IDLE must reach nobody.
    @(negedge clk);
    n_checks++; if ({i_mem_resp, d_mem_resp} !== 2'b00) $display("FAIL recover_resp_ignored: got %b want 00", {i_mem_resp, d_mem_resp}); else n_pass++;
    ca_mem_resp = 1'b0;
  endtask

  task automatic test_tie();
    bit ok;
    do_reset();
    i_mem_read = 1'b1; i_mem_address = 32'h100;
    d_mem_write = 1'b1; d_mem_address = 32'h200;
    d_mem_wdata = {8{32'hDEAD_BEEF}}; d_mem_byte_enable = '1;
    wait_ca_req(2, ok);
    n_checks++; if (!ok || {ca_mem_read, ca_mem_write} !== 2'b10 || ca_mem_address !== 32'h100) $display("FAIL tie_first_i: got rw=%b addr=%h want rw=10 addr=00000100", {ca_mem_read, ca_mem_write}, ca_mem_address); else n_pass++;
    ca_mem_rdata = rand_line(); ca_mem_resp = 1'b1;
    #1;
    n_checks++; if ({i_mem_resp, d_mem_resp} !== 2'b10) $display("FAIL tie_i_resp: got i=%b d=%b want i=1 d=0", i_mem_resp, d_mem_resp); else n_pass++;
    @(negedge clk);
    ca_mem_resp = 1'b0; i_mem_read = 1'b0;
    n_checks++; if ({ca_mem_read, ca_mem_write} !== 2'b00) $display("FAIL tie_recover: got %b want 00", {ca_mem_read, ca_mem_write}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({ca_mem_read, ca_mem_write} !== 2'b00) $display("FAIL tie_gap: got %b want 00", {ca_mem_read, ca_mem_write}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({ca_mem_read, ca_mem_write} !== 2'b01 || ca_mem_address !== 32'h200) $display("FAIL tie_second_d: got rw=%b addr=%h want rw=01 addr=00000200", {ca_mem_read, ca_mem_write}, ca_mem_address); else n_pass++;
    n_checks++; if (ca_mem_wdata !== {8{32'hDEAD_BEEF}} || ca_mem_byte_enable !== '1) $display("FAIL tie_d_wdata: got %h be=%h want deadbeef.. be=ff..", ca_mem_wdata, ca_mem_byte_enable); else n_pass++;
    ca_mem_resp = 1'b1;
    #1;
    n_checks++; if ({i_mem_resp, d_mem_resp} !== 2'b01) $display("FAIL tie_d_resp: got i=%b d=%b want i=0 d=1", i_mem_resp, d_mem_resp); else n_pass++;
    @(negedge clk);
    ca_mem_resp = 1'b0; d_mem_write = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit exp_d;
    int lat;
    i_mem_read = 1'b1; i_mem_address = 32'h400;
    d_mem_read = 1'b1; d_mem_address = 32'h800;
    for (int t = 0; t < 4; t++) begin
      exp_d = (t % 2 == 1);
      wait_ca_req(6, ok);
      n_checks++; if (!ok || ca_mem_read !== 1'b1 || ca_mem_address !== (exp_d ? 32'h800 : 32'h400)) $display("FAIL b2b_grant%0d: got rd=%b addr=%h want rd=1 addr=%h", t, ca_mem_read, ca_mem_address, exp_d ? 32'h800 : 32'h400); else n_pass++;
      lat = $urandom_range(0, 3);
      repeat (lat) @(negedge clk);
      ca_mem_rdata = rand_line(); ca_mem_resp = 1'b1;
      #1;
      n_checks++; if ({i_mem_resp, d_mem_resp} !== {!exp_d, exp_d}) $display("FAIL b2b_resp%0d: got i=%b d=%b want i=%b d=%b", t, i_mem_resp, d_mem_resp, !exp_d, exp_d); else n_pass++;
      @(negedge clk);
      ca_mem_resp = 1'b0;
      n_checks++; if ({i_mem_resp, d_mem_resp, ca_mem_read, ca_mem_write} !== 4'b0000) $display("FAIL b2b_single_resp%0d: got %b want 0000", t, {i_mem_resp, d_mem_resp, ca_mem_read, ca_mem_write}); else n_pass++;
    end
    i_mem_read = 1'b0; d_mem_read = 1'b0;
  endtask

  task automatic test_write_priority();
    bit ok;
    d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_address = 32'h300;
    d_mem_wdata = rand_line(); d_mem_byte_enable = 32'h0F0F_00FF;
    wait_ca_req(6, ok);
    n_checks++; if (!ok || {ca_mem_read, ca_mem_write} !== 2'b01 || ca_mem_address !== 32'h300) $display("FAIL write_priority: got rw=%b addr=%h want rw=01 addr=00000300", {ca_mem_read, ca_mem_write}, ca_mem_address); else n_pass++;
    n_checks++; if (ca_mem_byte_enable !== 32'h0F0F_00FF) $display("FAIL write_priority_be: got %h want 0f0f00ff", ca_mem_byte_enable); else n_pass++;
    ca_mem_resp = 1'b1;
    #1;
    n_checks++; if ({i_mem_resp, d_mem_resp} !== 2'b01) $display("FAIL write_priority_resp: got i=%b d=%b want i=0 d=1", i_mem_resp, d_mem_resp); else n_pass++;
    @(negedge clk);
    ca_mem_resp = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
  endtask

  // Free-running traffic: both caches issue randomly, the adaptor answers
  // after a random delay, and the expected winner comes from a round-robin
  // record of who was served last.
  task automatic test_random_traffic();
    bit model_last_d, busy, resp_live, exp_d, exp_wr, pend_i, pend_d;
    bit i_out, d_out;
    int lat, i_gap, d_gap, last_resp_cyc, stall, op;
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp_wdata, rd;
    logic [BE_W-1:0]   exp_be;
    do_reset();
    model_last_d = 1'b1; busy = 1'b0; resp_live = 1'b0; exp_d = 1'b0; exp_wr = 1'b0;
    i_out = 1'b0; d_out = 1'b0; i_gap = 0; d_gap = 0; lat = 0; stall = 0;
    last_resp_cyc = -10; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      @(negedge clk);
      if (resp_live) begin
        n_checks++; if ({ca_mem_read, ca_mem_write} !== 2'b00) $display("FAIL rand_recover_low: got %b want 00 at cycle %0d", {ca_mem_read, ca_mem_write}, cyc); else n_pass++;
        ca_mem_resp = 1'b0;
        if (exp_d) begin
          d_out = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0; d_gap = $urandom_range(0, 3);
        end else begin
          i_out = 1'b0; i_mem_read = 1'b0; i_gap = $urandom_range(0, 3);
        end
        resp_live = 1'b0; busy = 1'b0; last_resp_cyc = cyc - 1; stall = 0;
      end else if (busy) begin
        n_checks++; if ({ca_mem_read, ca_mem_write, ca_mem_address, ca_mem_wdata, ca_mem_byte_enable} !== {!exp_wr, exp_wr, exp_addr, exp_wdata, exp_be}) $display("FAIL rand_hold: got rw=%b addr=%h want rw=%b addr=%h at cycle %0d", {ca_mem_read, ca_mem_write}, ca_mem_address, {!exp_wr, exp_wr}, exp_addr, cyc); else n_pass++;
        if (lat == 0) begin
          rd = rand_line(); ca_mem_rdata = rd; ca_mem_resp = 1'b1;
          #1;
          n_checks++; if ({i_mem_resp, d_mem_resp} !== {!exp_d, exp_d}) $display("FAIL rand_resp_route: got i=%b d=%b want i=%b d=%b at cycle %0d", i_mem_resp, d_mem_resp, !exp_d, exp_d, cyc); else n_pass++;
          n_checks++; if ((exp_d ? d_mem_rdata : i_mem_rdata) !== rd) $display("FAIL rand_rdata: got %h want %h", exp_d ? d_mem_rdata : i_mem_rdata, rd); else n_pass++;
          resp_live = 1'b1;
        end else begin
          lat--;
          // Winner may drop its request early; the transaction must still complete.
          if ($urandom_range(0, 3) == 0) begin
            if (exp_d) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
            else i_mem_read = 1'b0;
          end
        end
      end else if (ca_mem_read || ca_mem_write) begin
        pend_i = i_mem_read;
        pend_d = d_mem_read | d_mem_write;
        exp_d  = (pend_i && pend_d) ? !model_last_d : pend_d;
        exp_wr   = exp_d ? d_mem_write : 1'b0;
        exp_addr = exp_d ? d_mem_address : i_mem_address;
        exp_wdata = exp_d ? d_mem_wdata : '0;
        exp_be   = exp_d ? d_mem_byte_enable : '0;
        n_checks++; if ((pend_i | pend_d) !== 1'b1) $display("FAIL rand_spurious_grant: got request with nothing pending want none at cycle %0d", cyc); else n_pass++;
        n_checks++; if ({ca_mem_read, ca_mem_write, ca_mem_address, ca_mem_wdata, ca_mem_byte_enable} !== {!exp_wr, exp_wr, exp_addr, exp_wdata, exp_be}) $display("FAIL rand_grant: got rw=%b addr=%h want rw=%b addr=%h (winner d=%b) at cycle %0d", {ca_mem_read, ca_mem_write}, ca_mem_address, {!exp_wr, exp_wr}, exp_addr, exp_d, cyc); else n_pass++;
        n_checks++; if (cyc - last_resp_cyc < 3) $display("FAIL rand_spacing: got %0d cycles want >= 3", cyc - last_resp_cyc); else n_pass++;
        n_checks++; if (stall > 1) $display("FAIL rand_grant_latency: got %0d idle cycles want <= 1", stall); else n_pass++;
        model_last_d = exp_d; busy = 1'b1; lat = $urandom_range(0, 4); stall = 0;
      end else if (i_mem_read || d_mem_read || d_mem_write) begin
        stall++;
      end
      if (cyc < 1500) begin
        if (!i_out) begin
          if (i_gap > 0) i_gap--;
          else begin
            i_out = 1'b1; i_mem_read = 1'b1; i_mem_address = $urandom;
          end
        end
        if (!d_out) begin
          if (d_gap > 0) d_gap--;
          else begin
            op = $urandom_range(0, 2);
            d_out = 1'b1;
            d_mem_read = (op != 1); d_mem_write = (op != 0);
            d_mem_address = $urandom; d_mem_wdata = rand_line(); d_mem_byte_enable = $urandom;
          end
        end
      end
    end
    n_checks++; if ({i_out, d_out, busy} !== 3'b000) $display("FAIL rand_drain: got outstanding i=%b d=%b busy=%b want all 0", i_out, d_out, busy); else n_pass++;
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL rand_no_timeout: got %b want 0", err_timeout); else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    i_mem_read = 1'b1; i_mem_address = 32'h5000;
    wait_ca_req(3, ok);
    n_checks++; if (!ok || err_timeout !== 1'b0) $display("FAIL timeout_start: got req=%b err=%b want req=1 err=0", ok, err_timeout); else n_pass++;
    repeat (TMO - 1) @(negedge clk);
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL timeout_early: got %b want 0 after %0d busy cycles", err_timeout, TMO - 1); else n_pass++;
    @(negedge clk);
    n_checks++; if (err_timeout !== 1'b1) $display("FAIL timeout_set: got %b want 1 after %0d busy cycles", err_timeout, TMO); else n_pass++;
    n_checks++; if (ca_mem_read !== 1'b1 || ca_mem_address !== 32'h5000) $display("FAIL timeout_no_abort: got rd=%b addr=%h want rd=1 addr=00005000", ca_mem_read, ca_mem_address); else n_pass++;
    repeat (3) @(negedge clk);
    ca_mem_rdata = rand_line(); ca_mem_resp = 1'b1;
    #1;
    n_checks++; if ({i_mem_resp, d_mem_resp} !== 2'b10) $display("FAIL timeout_late_resp: got i=%b d=%b want i=1 d=0", i_mem_resp, d_mem_resp); else n_pass++;
    @(negedge clk);
    ca_mem_resp = 1'b0; i_mem_read = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (err_timeout !== 1'b1 || ca_mem_read !== 1'b0) $display("FAIL timeout_sticky: got err=%b rd=%b want err=1 rd=0", err_timeout, ca_mem_read); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    d_mem_write = 1'b1; d_mem_address = 32'h600;
    d_mem_wdata = rand_line(); d_mem_byte_enable = '1;
    wait_ca_req(3, ok);
    n_checks++; if (!ok || ca_mem_write !== 1'b1) $display("FAIL reset_mid_setup: got wr=%b want 1", ca_mem_write); else n_pass++;
    @(negedge clk);
    #2;
    rst = 1'b0; ca_mem_resp = 1'b1;
    #1;
    n_checks++; if ({ca_mem_read, ca_mem_write} !== 2'b00) $display("FAIL reset_mid_async: got rw=%b want 00", {ca_mem_read, ca_mem_write}); else n_pass++;
    n_checks++; if ({i_mem_resp, d_mem_resp} !== 2'b00) $display("FAIL reset_mid_no_resp: got i=%b d=%b want 0 0", i_mem_resp, d_mem_resp); else n_pass++;
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL reset_mid_err: got %b want 0", err_timeout); else n_pass++;
    @(negedge clk);
    ca_mem_resp = 1'b0; d_mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    i_mem_read = 1'b1; i_mem_address = 32'h700;
    d_mem_read = 1'b1; d_mem_address = 32'h800;
    wait_ca_req(3, ok);
    n_checks++; if (!ok || {ca_mem_read, ca_mem_write} !== 2'b10 || ca_mem_address !== 32'h700) $display("FAIL reset_mid_tie_i: got rw=%b addr=%h want rw=10 addr=00000700", {ca_mem_read, ca_mem_write}, ca_mem_address); else n_pass++;
    ca_mem_resp = 1'b1;
    #1;
    n_checks++; if ({i_mem_resp, d_mem_resp} !== 2'b10) $display("FAIL reset_mid_tie_resp: got i=%b d=%b want i=1 d=0", i_mem_resp, d_mem_resp); else n_pass++;
    @(negedge clk);
    ca_mem_resp = 1'b0; i_mem_read = 1'b0; d_mem_read = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    i_mem_read = 1'b0; i_mem_address = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0;
    d_mem_wdata = '0; d_mem_byte_enable = '0;
    ca_mem_rdata = '0; ca_mem_resp = 1'b0;
    test_reset();
    test_i_read();
    test_tie();
    test_back_to_back();
    test_write_priority();
    test_random_traffic();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Two-requester arbiter that shares the single cacheline adaptor port between the instruction cache (read-only) and the data cache (read/write), 256-bit line transactions.
- Sits between both caches and the cacheline adaptor. Latches the winning request, drives the adaptor port from registers, and routes the response back to the winner only.
- Round-robin arbitration. A sticky watchdog flags an adaptor that never responds.

Parameters:
- ADDR_W, 32, line address width.
- LINE_W, 256, cache line width.
- TIMEOUT_CYCLES, 1024, busy cycles without ca_mem_resp before err_timeout sets; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- i_mem_read  in  1  I-cache line read request, held until i_mem_resp
- i_mem_address  in  ADDR_W  I-cache line address
- i_mem_rdata  out  LINE_W  I-cache read data
- i_mem_resp  out  1  I-cache completion pulse
- d_mem_read  in  1  D-cache line read request, held until d_mem_resp
- d_mem_write  in  1  D-cache line write request, held until d_mem_resp
- d_mem_address  in  ADDR_W  D-cache line address
- d_mem_wdata  in  LINE_W  D-cache write data
- d_mem_byte_enable  in  LINE_W/8  D-cache byte enables
- d_mem_rdata  out  LINE_W  D-cache read data
- d_mem_resp  out  1  D-cache completion pulse
- ca_mem_read  out  1  adaptor read request (registered)
- ca_mem_write  out  1  adaptor write request (registered)
- ca_mem_address  out  ADDR_W  adaptor address (registered)
- ca_mem_wdata  out  LINE_W  adaptor write data (registered)
- ca_mem_byte_enable  out  LINE_W/8  adaptor byte enables (registered)
- ca_mem_rdata  in  LINE_W  adaptor read data
- ca_mem_resp  in  1  adaptor completion pulse
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All ca_* outputs 0; err_timeout=0; watchdog counter 0.
  - last_grant=D, so the I-cache wins the first tie.
- States: IDLE, BUSY_I, BUSY_D, RECOVER.
- IDLE:
  - I request pending = i_mem_read. D request pending = d_mem_read or d_mem_write.
  - Only one pending: that requester wins.
  - Both pending: the requester that is not last_grant wins.
  - On a win: latch address, wdata, byte_enable (zeros for I) and the op into the ca_* registers; update last_grant; move to BUSY_I or BUSY_D.
  - Request seen in cycle N -> ca_mem_read/ca_mem_write high from cycle N+1.
- D op select: d_mem_write=1 means write. If d_mem_read and d_mem_write are both 1, write wins. I is always a read.
- BUSY_x:
  - ca_* outputs are held stable; requester inputs are ignored.
  - x_mem_resp = ca_mem_resp (combinational, same cycle). The other requester's resp stays 0.
  - When ca_mem_resp=1: move to RECOVER; clear ca_mem_read and ca_mem_write at the next edge.
- RECOVER: one cycle with ca request low, so the adaptor sees the deassert; then IDLE. Minimum spacing between adaptor requests is 3 cycles.
- Read data:
  - i_mem_rdata and d_mem_rdata are both wired to ca_mem_rdata.
  - A cache samples rdata only with its own resp.
- Watchdog:
  - Counter increments in BUSY_x and clears on entry to BUSY_x.
  - When the count reaches TIMEOUT_CYCLES with no ca_mem_resp, err_timeout sets and stays set until reset.
  - The transaction is not aborted.
  - Counter saturates at the limit.
- Boundaries:
  - A requester dropping its request mid-transaction does not cancel it; the latched op completes and resp still pulses.
  - ca_mem_resp in IDLE or RECOVER is ignored: no requester resp.
  - Reset mid-transaction: ca request drops immediately (async) and no resp is generated.
  - A new request arriving during BUSY or RECOVER waits in IDLE arbitration.

Test Plan:
- Reset then I read 0x0000_1000 alone -> ca_mem_read=1, ca_mem_address=0x1000 one cycle later. Adaptor returns resp with rdata=0xA5..A5 -> i_mem_resp=1 and i_mem_rdata=0xA5..A5 that cycle; d_mem_resp stays 0.
- I read 0x100 and D write 0x200 (wdata=0xDEAD..BEEF, be=all ones) in the same cycle after reset:
  - I served first.
  - After RECOVER, D is served with ca_mem_write=1, address 0x200, wdata matching.
- Both request continuously for 4 transactions -> grant order I, D, I, D. Exactly one resp per transaction to the correct cache.
- d_mem_read=d_mem_write=1, address 0x300 -> ca_mem_write=1 and ca_mem_read=0.
- TIMEOUT_CYCLES=8, adaptor silent -> err_timeout=1 after 8 busy cycles. A later resp completes normally and err_timeout stays 1.
- Assert rst low during BUSY_D -> ca_mem_write=0 immediately, no d_mem_resp. After release, the next tie grants I.
